// File: rtl/jk_bank_driver_pkg.sv
// Shared definitions for the J-K bank driver: FSM encodings, op codes and retry counter width.
// Readback checking is compiled in when JK_BANK_READBACK_EN is defined.
package jk_bank_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_TOGGLE = 1'b1;

    localparam int RETRY_W = 3;

endpackage

// File: rtl/jk_excitation_encoder.sv
// Per-bit J/K excitation: maps (current, target, op, mask, shadow-known) to the J/K pair
// that moves one J-K flip-flop to the requested value.
module jk_excitation_encoder
    import jk_bank_driver_pkg::*;
(
    input  logic cur,
    input  logic tgt,
    input  logic op,
    input  logic mask,
    input  logic init,
    output logic j,
    output logic k
);

    always_comb begin
        j = 1'b0;
        k = 1'b0;
        if (mask) begin
            if (op == OP_TOGGLE) begin
                j = 1'b1;
                k = 1'b1;
            end else if (!init) begin
                // Current state unknown: force the bit with an explicit set or reset.
                j = tgt;
                k = ~tgt;
            end else begin
                j = ~cur & tgt;
                k = cur & ~tgt;
            end
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of WIDTH J-K flip-flops from a valid/ready request stream, keeping a shadow copy.
// Define JK_BANK_READBACK_EN to add readback verification with up to MAX_RETRY re-drives.
module jk_bank_driver
    import jk_bank_driver_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_mask,
    input  logic [WIDTH-1:0] req_target,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] state_q,
    output logic             done,
    output logic             error
);

    state_t           state, state_nxt;
    logic             shadow_valid;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] exp_next;
    logic             accept;
    logic             toggle_bad;

    logic [WIDTH-1:0] enc_cur, enc_tgt, enc_mask, enc_j, enc_k;
    logic             enc_op, enc_init;

    assign accept     = req_valid & req_ready;
    assign toggle_bad = (req_op == OP_TOGGLE) && !shadow_valid;
    assign exp_next   = (req_mask & ((req_op == OP_TOGGLE) ? ~state_q : req_target))
                      | (~req_mask & state_q);

`ifdef JK_BANK_READBACK_EN
    logic [RETRY_W-1:0] retry_cnt;
    logic               mismatch;
    logic               retry_ok;

    assign mismatch = |((q_fb ^ state_q) & mask_r);
    assign retry_ok = retry_cnt < RETRY_W'(MAX_RETRY);

    // A retry re-drives as a LOAD from the observed bank value to the expected value.
    always_comb begin
        if (state == ST_VERIFY) begin
            enc_cur  = q_fb;
            enc_tgt  = exp_r;
            enc_op   = OP_LOAD;
            enc_mask = mask_r;
            enc_init = 1'b1;
        end else begin
            enc_cur  = state_q;
            enc_tgt  = req_target;
            enc_op   = req_op;
            enc_mask = req_mask;
            enc_init = shadow_valid;
        end
    end
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;

    assign enc_cur  = state_q;
    assign enc_tgt  = req_target;
    assign enc_op   = req_op;
    assign enc_mask = req_mask;
    assign enc_init = shadow_valid;
`endif

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
        jk_excitation_encoder u_enc (
            .cur  (enc_cur[gi]),
            .tgt  (enc_tgt[gi]),
            .op   (enc_op),
            .mask (enc_mask[gi]),
            .init (enc_init),
            .j    (enc_j[gi]),
            .k    (enc_k[gi])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = toggle_bad ? ST_DONE : ST_DRIVE;
`ifdef JK_BANK_READBACK_EN
            ST_DRIVE:  state_nxt = ST_VERIFY;
            ST_VERIFY: state_nxt = (mismatch && retry_ok) ? ST_DRIVE : ST_DONE;
`else
            ST_DRIVE:  state_nxt = ST_DONE;
`endif
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        done      = (state == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            j            <= '0;
            k            <= '0;
            state_q      <= '0;
            shadow_valid <= 1'b0;
            error        <= 1'b0;
`ifdef JK_BANK_READBACK_EN
            retry_cnt    <= '0;
`endif
        end else begin
            j <= '0;
            k <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        error <= toggle_bad;
                        if (!toggle_bad) begin
                            j <= enc_j;
                            k <= enc_k;
                        end
`ifdef JK_BANK_READBACK_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                ST_DRIVE: begin
                    state_q <= exp_r;
`ifndef JK_BANK_READBACK_EN
                    shadow_valid <= 1'b1;
`endif
                end
`ifdef JK_BANK_READBACK_EN
                ST_VERIFY: begin
                    if (!mismatch) begin
                        shadow_valid <= 1'b1;
                    end else if (retry_ok) begin
                        j         <= enc_j;
                        k         <= enc_k;
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                    end else begin
                        error        <= 1'b1;
                        state_q      <= q_fb;
                        shadow_valid <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Request fields are held from accept until the request completes.
    always_ff @(posedge clock) begin
        if (accept) begin
            mask_r <= req_mask;
            exp_r  <= exp_next;
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver driving a modelled bank of four J-K flip-flops.
// Build with JK_BANK_READBACK_EN defined to include the forced-readback retry sequence.
module tb_jk_bank_driver;
    import jk_bank_driver_pkg::*;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [W-1:0] req_mask;
    logic [W-1:0] req_target;
    logic [W-1:0] j, k;
    logic [W-1:0] q_fb;
    logic [W-1:0] state_q;
    logic         done;
    logic         error;

    logic [W-1:0] bank_q;
    logic [W-1:0] force_mask;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clock = ~clock;

    // Bank of J-K flops: Q+ = J&~Q | ~K&Q; readback can have bits forced low.
    always @(posedge clock) begin
        if (reset) bank_q <= '0;
        else       bank_q <= (j & ~bank_q) | (~k & bank_q);
    end
    assign q_fb = bank_q & ~force_mask;

    jk_bank_driver #(.WIDTH(W), .MAX_RETRY(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_mask   (req_mask),
        .req_target (req_target),
        .j          (j),
        .k          (k),
        .q_fb       (q_fb),
        .state_q    (state_q),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        bit           rst;
        logic         op;
        logic [W-1:0] mask;
        logic [W-1:0] tgt;
        logic [W-1:0] ej;
        logic [W-1:0] ek;
        logic [W-1:0] eq;
        logic         eerr;
        int           ndrv;
    } vec_t;

    vec_t vecs[8];
    vec_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_req(input vec_t v);
        vec_t e;
        int   n;
        int   lat;
        bit   got;
        sbq.push_back(v);
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        req_valid  = 1'b1;
        req_op     = v.op;
        req_mask   = v.mask;
        req_target = v.tgt;
        @(posedge clock);
        @(negedge clock);
        req_valid  = 1'b0;
        req_op     = ~v.op;
        req_mask   = ~v.mask;
        req_target = ~v.tgt;
        e = sbq[0];
        chk("first_j", 32'(j), 32'(e.ej));
        chk("first_k", 32'(k), 32'(e.ek));
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clock);
            if (done) begin
                got = 1'b1;
                e = sbq.pop_front();
`ifdef JK_BANK_READBACK_EN
                lat = 2 * e.ndrv;
`else
                lat = e.ndrv;
`endif
                chk("latency", 32'(c), 32'(lat));
                chk("state_q", 32'(state_q), 32'(e.eq));
                chk("bank_q", 32'(q_fb), 32'(e.eq));
                chk("error", 32'(error), 32'(e.eerr));
                break;
            end
        end
        if (!got) begin
            chk("done_timeout", 32'(0), 32'(1));
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else begin
            @(negedge clock);
            chk("done_one_cycle", 32'(done), 32'(0));
            chk("ready_after", 32'(req_ready), 32'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   done_seen;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = OP_LOAD;
        req_mask   = '0;
        req_target = '0;
        force_mask = '0;

        //        rst  op         mask     tgt      j        k        q        err  ndrv
        vecs[0] = '{1'b1, OP_LOAD,   4'b1111, 4'b1010, 4'b1010, 4'b0101, 4'b1010, 1'b0, 1};
        vecs[1] = '{1'b0, OP_LOAD,   4'b0011, 4'b0101, 4'b0001, 4'b0010, 4'b1001, 1'b0, 1};
        vecs[2] = '{1'b0, OP_TOGGLE, 4'b1100, 4'b0000, 4'b1100, 4'b1100, 4'b0101, 1'b0, 1};
        vecs[3] = '{1'b0, OP_TOGGLE, 4'b1100, 4'b1111, 4'b1100, 4'b1100, 4'b1001, 1'b0, 1};
        vecs[4] = '{1'b0, OP_LOAD,   4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1001, 1'b0, 1};
        vecs[5] = '{1'b0, OP_LOAD,   4'b1111, 4'b0110, 4'b0110, 4'b1001, 4'b0110, 1'b0, 1};
        vecs[6] = '{1'b1, OP_TOGGLE, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0};
        vecs[7] = '{1'b0, OP_LOAD,   4'b1111, 4'b0011, 4'b0011, 4'b1100, 4'b0011, 1'b0, 1};

        do_reset();
        chk("rst_j", 32'(j), 32'(0));
        chk("rst_k", 32'(k), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        chk("rst_state_q", 32'(state_q), 32'(0));

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst && i > 0) do_reset();
            run_req(vecs[i]);
        end

        // Reset asserted in the DRIVE cycle aborts the request.
        do_reset();
        v = '{1'b0, OP_LOAD, 4'b1111, 4'b0101, 4'b0101, 4'b1010, 4'b0101, 1'b0, 1};
        req_valid  = 1'b1;
        req_op     = v.op;
        req_mask   = v.mask;
        req_target = v.tgt;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("abort_drive_j", 32'(j), 32'(v.ej));
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort_j", 32'(j), 32'(0));
        chk("abort_k", 32'(k), 32'(0));
        chk("abort_ready", 32'(req_ready), 32'(1));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_state_q", 32'(state_q), 32'(0));
        reset = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            done_seen |= done;
        end
        chk("abort_no_done", 32'(done_seen), 32'(0));
        // Shadow must be invalid again: a TOGGLE is refused.
        run_req('{1'b0, OP_TOGGLE, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0});

`ifdef JK_BANK_READBACK_EN
        // Bit 0 never reads back as 1: two retries, then failure with shadow = readback.
        do_reset();
        force_mask = 4'b0001;
        run_req('{1'b0, OP_LOAD, 4'b1111, 4'b0001, 4'b0001, 4'b1110, 4'b0000, 1'b1, 3});
        force_mask = 4'b0000;
        run_req('{1'b0, OP_LOAD, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0011, 1'b0, 1});
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
